// File: rtl/img_pkg.sv
// Shared frame-buffer geometry, capture state and pixel types for the camera
// capture path and the VGA reader.
package img_pkg;

  localparam int unsigned IMG_W_DEFAULT = 320;
  localparam int unsigned IMG_H_DEFAULT = 240;
  localparam int unsigned IMG_ADDR_W    = $clog2(IMG_W_DEFAULT * IMG_H_DEFAULT);
  localparam int unsigned BYTE_W        = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // The first byte on the bus carries R and the upper G bits.
  function automatic rgb565_t pack_pixel(input logic [BYTE_W-1:0] hi,
                                         input logic [BYTE_W-1:0] lo);
    return rgb565_t'({hi, lo});
  endfunction

endpackage

// File: rtl/ov7670_byte_assembler.sv
// Pairs OV7670 bus bytes into RGB565 pixels: byte-phase toggle, high-byte
// latch and a combinational pixel strobe on the second byte.
module ov7670_byte_assembler
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clear,
  input  logic              href,
  input  logic [BYTE_W-1:0] data,
  output logic              pix_valid_c,
  output rgb565_t           pix_c
);

  logic              phase;
  logic [BYTE_W-1:0] hi;

  // A clear wins over everything so a dangling odd byte never pairs up
  // with the first byte of the next line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 1'b0;
      hi    <= '0;
    end else if (clear) begin
      phase <= 1'b0;
    end else if (en && href) begin
      if (!phase) hi <= data;
      phase <= ~phase;
    end
  end

  assign pix_valid_c = en & href & phase & ~clear;
  assign pix_c       = pack_pixel(hi, data);

endmodule

// File: rtl/ov7670_mem_writer.sv
// OV7670 RGB565 capture into the frame buffer at IMG_W*y + x.
// Define CAM_DECIMATE_EN for a VGA sensor stored 2:1 in both axes.
module ov7670_mem_writer
  import img_pkg::*;
#(
  parameter  int unsigned IMG_W  = IMG_W_DEFAULT,
  parameter  int unsigned IMG_H  = IMG_H_DEFAULT,
  localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_en,
  input  logic              vsync,
  input  logic              href,
  input  logic [BYTE_W-1:0] data,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic              busy
);

`ifdef CAM_DECIMATE_EN
  localparam int unsigned DEC_SH = 1;
`else
  localparam int unsigned DEC_SH = 0;
`endif
  localparam int unsigned COL_MAX = IMG_W << DEC_SH;
  localparam int unsigned ROW_MAX = IMG_H << DEC_SH;
  localparam int unsigned COL_W   = $clog2(COL_MAX + 1);
  localparam int unsigned ROW_W   = $clog2(ROW_MAX + 1);

  cap_state_e        state;
  logic              vsync_r, vsync_d, href_r, href_d;
  logic [BYTE_W-1:0] data_r;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              line_pix;

  logic              vsync_fall_c, vsync_rise_c, href_fall_c, start_c;
  logic              pix_valid_c, keep_c, in_range_c;
  rgb565_t           pix_c;
  logic [ADDR_W-1:0] addr_c;

  assign vsync_fall_c = vsync_d & ~vsync_r;
  assign vsync_rise_c = ~vsync_d & vsync_r;
  assign href_fall_c  = href_d & ~href_r;
  assign start_c      = (state == IDLE) & vsync_fall_c & capture_en;

  ov7670_byte_assembler u_asm (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (state == ACTIVE),
    .clear       (href_fall_c | start_c),
    .href        (href_r),
    .data        (data_r),
    .pix_valid_c (pix_valid_c),
    .pix_c       (pix_c)
  );

  // Only even input columns and rows survive decimation.
`ifdef CAM_DECIMATE_EN
  assign keep_c = ~col[0] & ~row[0];
`else
  assign keep_c = 1'b1;
`endif

  assign in_range_c = keep_c && (col < COL_W'(COL_MAX)) && (row < ROW_W'(ROW_MAX));
  assign addr_c     = ADDR_W'(IMG_W) * ADDR_W'(row >> DEC_SH) + ADDR_W'(col >> DEC_SH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      vsync_r    <= 1'b0;
      vsync_d    <= 1'b0;
      href_r     <= 1'b0;
      href_d     <= 1'b0;
      data_r     <= '0;
      col        <= '0;
      row        <= '0;
      line_pix   <= 1'b0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vsync_r    <= vsync;
      vsync_d    <= vsync_r;
      href_r     <= href;
      href_d     <= href_r;
      data_r     <= data;
      we         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_c) begin
            state    <= ACTIVE;
            busy     <= 1'b1;
            col      <= '0;
            row      <= '0;
            line_pix <= 1'b0;
          end
        end
        ACTIVE: begin
          if (pix_valid_c) begin
            line_pix <= 1'b1;
            if (in_range_c) begin
              we    <= 1'b1;
              wAddr <= addr_c;
              wData <= pix_c;
            end
            if (col < COL_W'(COL_MAX)) col <= col + COL_W'(1);
          end
          // Lines that never completed a pixel do not advance the row.
          if (href_fall_c) begin
            col      <= '0;
            line_pix <= 1'b0;
            if (line_pix && (row < ROW_W'(ROW_MAX))) row <= row + ROW_W'(1);
          end
          if (vsync_rise_c) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_mem_writer.sv
// Scoreboard bench for ov7670_mem_writer in its default QVGA build.
module tb_ov7670_mem_writer;

  localparam int W = 320;
  localparam int H = 240;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_en = 1'b0;
  logic        vsync = 1'b1;
  logic        href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        we;
  logic [16:0] wAddr;
  logic [15:0] wData;
  logic        frame_done;
  logic        busy;

  ov7670_mem_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture_en (capture_en),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         wr_q[$];
  int          fd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          nwrites = 0;
  int          nframes = 0;
  int unsigned last_addr = 0;
  bit          exp_active = 1'b0;
  int          exp_y = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or ends a frame.
  always @(negedge clk) begin : monitor
    wr_t e;
    int  c;
    if (we === 1'b1) begin
      nwrites++;
      last_addr = wAddr;
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: wAddr=%0d wData=%h at cycle %0d", wAddr, wData, cyc);
      end else begin
        e = wr_q.pop_front();
        chk("write_addr", longint'(wAddr), longint'(e.addr));
        chk("write_data", longint'(wData), longint'(e.data));
        chk("write_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
    if (frame_done === 1'b1) begin
      nframes++;
      if (fd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: at cycle %0d", cyc);
      end else begin
        c = fd_q.pop_front();
        chk("frame_done_cycle", longint'(cyc), longint'(c));
        chk("busy_with_done", longint'(busy), 0);
      end
    end
  end

  task automatic put_byte(input logic [7:0] b, output int c);
    @(negedge clk);
    href = 1'b1;
    data = b;
    c    = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1'b0;
      data = 8'h00;
    end
  endtask

  // Drives one line; the expected write lands 2 clk after the second byte.
  task automatic send_line(input int npix, input bit odd_tail);
    int         c;
    logic [7:0] hi, lo;
    for (int x = 0; x < npix; x++) begin
      hi = 8'(exp_y * 7 + x);
      lo = 8'(x * 3 + exp_y) ^ 8'hA5;
      if (exp_y == 2 && x == 5) begin
        hi = 8'hF8;
        lo = 8'h1F;
      end
      put_byte(hi, c);
      put_byte(lo, c);
      if (exp_active && x < W && exp_y < H)
        wr_q.push_back('{addr: int'(W * exp_y + x), data: {hi, lo}, cyc: c + 2});
    end
    if (odd_tail) put_byte(8'hEE, c);
    idle(4);
    if (npix > 0 && exp_y < H) exp_y++;
  endtask

  task automatic frame_start(input bit en);
    @(negedge clk);
    vsync      = 1'b1;
    capture_en = en;
    repeat (3) @(negedge clk);
    vsync      = 1'b0;
    exp_active = en;
    exp_y      = 0;
    idle(3);
  endtask

  task automatic frame_end();
    @(negedge clk);
    vsync = 1'b1;
    if (exp_active) fd_q.push_back(cyc + 2);
    exp_active = 1'b0;
    idle(4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_we", longint'(we), 0);
    chk("reset_waddr", longint'(wAddr), 0);
    chk("reset_wdata", longint'(wData), 0);
    chk("reset_frame_done", longint'(frame_done), 0);
    chk("reset_busy", longint'(busy), 0);
    reset_n = 1'b1;
    idle(2);

    // Frame A: normal capture with boundary lines.
    frame_start(1'b1);
    chk("busy_active", longint'(busy), 1);
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    send_line(6, 1'b0);
    chk("pixel_x5_y2_addr", longint'(last_addr), 645);
    send_line(321, 1'b1);
    chk("overlong_line_last_addr", longint'(last_addr), 1279);
    chk("overlong_line_writes", longint'(nwrites), 334);
    send_line(0, 1'b1);
    send_line(1, 1'b0);
    chk("next_line_x0", longint'(last_addr), 1280);
    repeat (234) send_line(1, 1'b0);
    send_line(320, 1'b0);
    chk("max_addr", longint'(last_addr), 76799);
    repeat (3) send_line(2, 1'b0);
    frame_end();
    chk("frame_a_writes", longint'(nwrites), 889);
    chk("frame_a_done_count", longint'(nframes), 1);

    // Frame B: not armed at the vsync fall, armed mid-frame.
    frame_start(1'b0);
    send_line(3, 1'b0);
    chk("busy_not_armed", longint'(busy), 0);
    capture_en = 1'b1;
    send_line(3, 1'b0);
    send_line(3, 1'b0);
    frame_end();
    chk("frame_b_writes", longint'(nwrites), 889);
    chk("frame_b_done_count", longint'(nframes), 1);

    // Frame C: reset asserted at line 100.
    frame_start(1'b1);
    repeat (100) send_line(1, 1'b0);
    chk("pre_reset_addr", longint'(last_addr), 31680);
    chk("pre_reset_busy", longint'(busy), 1);
    @(negedge clk);
    reset_n = 1'b0;
    exp_active = 1'b0;
    #1;
    chk("async_reset_we", longint'(we), 0);
    chk("async_reset_waddr", longint'(wAddr), 0);
    chk("async_reset_wdata", longint'(wData), 0);
    chk("async_reset_busy", longint'(busy), 0);
    chk("async_reset_frame_done", longint'(frame_done), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) send_line(1, 1'b0);
    chk("post_reset_busy", longint'(busy), 0);
    frame_end();
    chk("frame_c_writes", longint'(nwrites), 989);

    // Frame D: restart from address 0.
    frame_start(1'b1);
    send_line(1, 1'b0);
    chk("restart_addr", longint'(last_addr), 0);
    chk("restart_writes", longint'(nwrites), 990);
    send_line(3, 1'b0);
    chk("restart_line1_addr", longint'(last_addr), 322);
    frame_end();
    idle(4);

    chk("write_queue_drained", longint'(wr_q.size()), 0);
    chk("done_queue_drained", longint'(fd_q.size()), 0);
    chk("total_frame_done", longint'(nframes), 2);
    chk("total_writes", longint'(nwrites), 993);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
